// File: rtl/fetch_pkg.sv
// Shared types and PC-select encodings for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  localparam logic [2:0] HOLD   = 3'd0;
  localparam logic [2:0] RET    = 3'd1;
  localparam logic [2:0] CALL   = 3'd2;
  localparam logic [2:0] JUMP   = 3'd3;
  localparam logic [2:0] BRANCH = 3'd4;
  localparam logic [2:0] INC    = 3'd5;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO; a push while full or a pop while empty is ignored here,
// and the sequencer records those events in its sticky flags.
module ret_addr_stack #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [D-1:0]     mem [RAS_DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] top_ptr;

  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign empty   = (count == '0);
  assign top_ptr = count - 1'b1;
  assign top     = empty ? '0 : mem[top_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (pop && !empty)
      count <= count - 1'b1;
    else if (push && !full)
      count <= count + 1'b1;
  end

  // Storage has no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && !clear && !pop && push && !full)
      mem[count[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run control: req/done handshake, end-address and halt
// detection, branch/jump/call/return with a return-address stack, run-cycle counter.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4,
  parameter int CW        = 16,
  parameter int END_ADDR  = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          jump_en,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          ras_ovf,
  output logic          ras_unf,
  output logic [CW-1:0] cycle_cnt
);
  localparam logic [D-1:0] END_PC = D'(END_ADDR);

  fetch_state_t state;
  logic [2:0]   pc_sel;
  logic         finish;
  logic         ras_clear;
  logic [D-1:0] ras_top;
  logic         ras_full;
  logic         ras_empty;

  assign finish = halt || (prog_ctr == END_PC);

  always_comb begin
    pc_sel = HOLD;
    if (state == RUN && !stall) begin
      if (finish)         pc_sel = HOLD;
      else if (ret_en)    pc_sel = RET;
      else if (call_en)   pc_sel = CALL;
      else if (jump_en)   pc_sel = JUMP;
      else if (branch_en) pc_sel = BRANCH;
      else                pc_sel = INC;
    end
  end

  assign ras_clear = (state != RUN) && req;

  ret_addr_stack #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (ras_clear),
    .push      (pc_sel == CALL),
    .pop       (pc_sel == RET),
    .push_data (prog_ctr + 1'b1),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            state     <= RUN;
            prog_ctr  <= start_addr;
            running   <= 1'b1;
            done      <= 1'b0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
            cycle_cnt <= '0;
          end
        end
        RUN: begin
          // Counts every RUN cycle, including stalls and the finishing cycle.
          if (cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 1'b1;
          if (!stall && finish) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
          case (pc_sel)
            RET: begin
              if (ras_empty) begin
                ras_unf  <= 1'b1;
                prog_ctr <= prog_ctr + 1'b1;
              end else begin
                prog_ctr <= ras_top;
              end
            end
            CALL: begin
              if (ras_full)
                ras_ovf <= 1'b1;
              prog_ctr <= target;
            end
            JUMP:    prog_ctr <= target;
            BRANCH:  prog_ctr <= prog_ctr + target;
            INC:     prog_ctr <= prog_ctr + 1'b1;
            default: prog_ctr <= prog_ctr;
          endcase
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer with D=8, RAS_DEPTH=2, CW=4, END_ADDR=128.
module tb_fetch_sequencer;
  localparam int D = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [D-1:0]  start_addr;
  logic          stall, halt, branch_en, jump_en, call_en, ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running, done, ras_ovf, ras_unf;
  logic [CW-1:0] cycle_cnt;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.D(D), .RAS_DEPTH(2), .CW(CW), .END_ADDR(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .start_addr (start_addr),
    .stall      (stall),
    .halt       (halt),
    .branch_en  (branch_en),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic [D-1:0]  sa;
    logic          stall, halt, br, jmp, call, ret;
    logic [D-1:0]  tgt;
    logic [D-1:0]  pc;
    logic          run, dn, ovf, unf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input int sa, input logic st, input logic h,
                     input logic b, input logic j, input logic c, input logic rt,
                     input int tgt, input int pc, input logic run, input logic dn,
                     input logic ovf, input logic unf, input int cnt);
    vec_t v;
    v.req = r; v.sa = D'(sa); v.stall = st; v.halt = h; v.br = b; v.jmp = j;
    v.call = c; v.ret = rt; v.tgt = D'(tgt); v.pc = D'(pc); v.run = run;
    v.dn = dn; v.ovf = ovf; v.unf = unf; v.cnt = CW'(cnt);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    req = v.req; start_addr = v.sa; stall = v.stall; halt = v.halt;
    branch_en = v.br; jump_en = v.jmp; call_en = v.call; ret_en = v.ret; target = v.tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [D-1:0] pc, input logic run,
                       input logic dn, input logic ovf, input logic unf,
                       input logic [CW-1:0] cnt);
    checks++;
    if (prog_ctr !== pc || running !== run || done !== dn || ras_ovf !== ovf ||
        ras_unf !== unf || cycle_cnt !== cnt) begin
      errors++;
      $display("FAIL %s: got pc=%0d run=%b done=%b ovf=%b unf=%b cnt=%0d, want pc=%0d run=%b done=%b ovf=%b unf=%b cnt=%0d",
               name, prog_ctr, running, done, ras_ovf, ras_unf, cycle_cnt,
               pc, run, dn, ovf, unf, cnt);
    end
  endtask

  initial begin
    vec_t idle_v;
    //   req sa  st h b j c r tgt  pc  run dn ovf unf cnt
    add(0,  0, 0,0,0,0,0,0,  0,   0, 0,0, 0,0,  0);  // IDLE holds
    add(1, 10, 0,0,0,0,0,0,  0,  10, 1,0, 0,0,  0);
    add(0,  0, 0,0,0,0,0,0,  0,  11, 1,0, 0,0,  1);
    add(0,  0, 0,0,0,0,0,0,  0,  12, 1,0, 0,0,  2);
    add(0,  0, 0,0,0,0,0,0,  0,  13, 1,0, 0,0,  3);
    add(0,  0, 0,0,0,0,0,0,  0,  14, 1,0, 0,0,  4);
    add(0,  0, 0,0,0,0,0,0,  0,  15, 1,0, 0,0,  5);
    add(0,  0, 0,1,0,0,0,0,  0,  15, 0,1, 0,0,  6);  // halt
    add(0,  0, 0,0,0,0,0,0,  0,  15, 0,1, 0,0,  6);
    add(1,125, 0,0,0,0,0,0,  0, 125, 1,0, 0,0,  0);
    add(0,  0, 0,0,0,0,0,0,  0, 126, 1,0, 0,0,  1);
    add(0,  0, 0,0,0,0,0,0,  0, 127, 1,0, 0,0,  2);
    add(0,  0, 0,0,0,0,0,0,  0, 128, 1,0, 0,0,  3);
    add(0,  0, 0,0,0,0,0,0,  0, 128, 0,1, 0,0,  4);  // END_ADDR reached
    add(1,  0, 0,0,0,0,0,0,  0,   0, 1,0, 0,0,  0);
    add(0,  0, 0,0,0,0,0,0,  0,   1, 1,0, 0,0,  1);
    add(0,  0, 0,0,0,0,0,0,  0,   2, 1,0, 0,0,  2);
    add(0,  0, 0,0,1,0,0,0,252, 254, 1,0, 0,0,  3);  // branch -4
    add(0,  0, 0,0,0,0,0,0,  0, 255, 1,0, 0,0,  4);
    add(0,  0, 0,0,0,0,0,0,  0,   0, 1,0, 0,0,  5);  // wrap
    add(0,  0, 0,0,0,0,0,0,  0,   1, 1,0, 0,0,  6);
    add(0,  0, 0,0,0,0,0,0,  0,   2, 1,0, 0,0,  7);
    add(0,  0, 0,0,0,0,0,0,  0,   3, 1,0, 0,0,  8);
    add(0,  0, 0,0,0,0,1,0, 20,  20, 1,0, 0,0,  9);  // push 4
    add(0,  0, 0,0,0,0,0,0,  0,  21, 1,0, 0,0, 10);
    add(0,  0, 0,0,0,0,1,0, 40,  40, 1,0, 0,0, 11);  // push 22
    add(0,  0, 0,0,0,0,0,0,  0,  41, 1,0, 0,0, 12);
    add(0,  0, 0,0,0,0,1,0, 60,  60, 1,0, 1,0, 13);  // overflow
    add(0,  0, 0,0,0,0,0,1,  0,  22, 1,0, 1,0, 14);
    add(0,  0, 0,0,0,0,0,1,  0,   4, 1,0, 1,0, 15);
    add(0,  0, 0,0,0,0,0,1,  0,   5, 1,0, 1,1, 15);  // underflow, saturated
    add(0,  0, 0,0,0,0,0,0,  0,   6, 1,0, 1,1, 15);
    add(0,  0, 0,0,0,0,0,0,  0,   7, 1,0, 1,1, 15);
    add(0,  0, 0,1,0,1,1,0, 99,   7, 0,1, 1,1, 15);  // halt beats call/jump
    add(1, 30, 0,0,0,0,0,0,  0,  30, 1,0, 0,0,  0);
    add(0,  0, 0,0,0,0,1,0, 50,  50, 1,0, 0,0,  1);  // push 31
    add(0,  0, 0,0,0,0,1,1, 70,  31, 1,0, 0,0,  2);  // ret beats call
    add(0,  0, 0,0,0,0,0,1,  0,  32, 1,0, 0,1,  3);  // nothing was pushed
    add(0,  0, 1,0,0,0,0,0,  0,  32, 1,0, 0,1,  4);
    add(0,  0, 1,0,0,1,0,0,  9,  32, 1,0, 0,1,  5);
    add(0,  0, 1,0,0,0,0,1,  0,  32, 1,0, 0,1,  6);
    add(1,100, 0,0,0,0,0,0,  0,  33, 1,0, 0,1,  7);  // req ignored in RUN
    add(0,  0, 0,0,0,1,0,0, 49,  49, 1,0, 0,1,  8);
    add(0,  0, 0,0,0,0,1,0, 50,  50, 1,0, 0,1,  9);  // RAS occupancy 1

    idle_v = vecs[0];
    drive(idle_v);
    reset = 1'b1;
    tick();
    tick();
    check("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].dn,
            vecs[i].ovf, vecs[i].unf, vecs[i].cnt);
    end

    // Reset mid-run at PC 50 with one RAS entry.
    drive(idle_v);
    reset = 1'b1;
    tick();
    check("midrun_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", 0, 0, 0, 0, 0, 0);
    req = 1'b1; start_addr = 8'd7;
    tick();
    check("restart", 7, 1, 0, 0, 0, 0);
    req = 1'b0; ret_en = 1'b1;
    tick();
    check("ras_empty_after_reset", 8, 1, 0, 0, 1, 1);
    ret_en = 1'b0;

    // DONE ignores enables and holds everything until req.
    halt = 1'b1;
    tick();
    check("halt_again", 8, 0, 1, 0, 1, 2);
    halt = 1'b0; jump_en = 1'b1; target = 8'd77;
    tick();
    check("done_holds", 8, 0, 1, 0, 1, 2);
    jump_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the core's program counter and run-control logic.
- Adds several capabilities over the current fixed scheme:
  - req/done run handshake with a programmable start address.
  - Programmable end address and halt detection, replacing the hard-wired "done at PC 128".
  - Relative branch, absolute jump, call/return through a return-address stack, and a stall input.
  - A run-cycle counter.
- Sits between control decoder / PC LUT and instr_ROM; drives prog_ctr and done for the top level.

Parameters:
- D, 12, program counter width.
- RAS_DEPTH, 4, return-address stack entries (>=1).
- CW, 16, cycle counter width.
- END_ADDR, 128, PC value that terminates a run (must fit in D bits).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; sampled in IDLE or DONE.
- start_addr  in  D  PC loaded when a run starts.
- stall  in  1  freeze PC, RAS and FSM for this cycle.
- halt  in  1  halt instruction decoded.
- branch_en  in  1  relative branch taken.
- jump_en  in  1  absolute jump.
- call_en  in  1  call: push return address, jump to target.
- ret_en  in  1  return: pop PC.
- target  in  D  absolute target, or two's-complement offset when branch_en.
- prog_ctr  out  D  current PC.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- ras_ovf  out  1  sticky, push attempted while stack full.
- ras_unf  out  1  sticky, pop attempted while stack empty.
- cycle_cnt  out  CW  cycles spent in RUN, saturating.

Behaviour:
- Reset values: state IDLE, prog_ctr=0, running=0, done=0, ras_ovf=0, ras_unf=0, cycle_cnt=0, RAS empty. Reset asserted mid-run aborts the run identically.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - req=1 → next cycle: prog_ctr=start_addr, state RUN, cycle_cnt=0, ras_ovf/ras_unf cleared, RAS emptied.
  - req=0 → hold.
- RUN:
  - req is ignored.
  - stall=1 → prog_ctr, RAS, state and flags hold; cycle_cnt still increments.
  - stall=0 → evaluate in this priority order:
    1. halt=1 or prog_ctr==END_ADDR → state DONE; prog_ctr holds.
    2. ret_en → prog_ctr=top of RAS, pop. If RAS is empty: ras_unf<=1 and prog_ctr=prog_ctr+1.
    3. call_en → push prog_ctr+1, then prog_ctr=target. If RAS is full: ras_ovf<=1, push dropped, jump still taken.
    4. jump_en → prog_ctr=target.
    5. branch_en → prog_ctr=prog_ctr+target, signed, modulo 2^D.
    6. otherwise → prog_ctr=prog_ctr+1, modulo 2^D (wraps to 0 from 2^D-1).
  - Multiple enables asserted together resolve strictly by this priority; lower-priority enables are discarded.
  - cycle_cnt increments by 1 on every RUN cycle and saturates at 2^CW-1.
- DONE:
  - done=1; prog_ctr, cycle_cnt and flags hold for inspection.
  - req=1 → restart exactly as from IDLE; done drops the cycle after req is sampled.
- Outputs are registered: running==(state==RUN), done==(state==DONE), no combinational paths from inputs.
- Latency: one cycle from a sampled req or control enable to the new prog_ctr.
- RAS:
  - LIFO with occupancy count 0..RAS_DEPTH.
  - Push and pop never occur in the same cycle, because ret wins.
  - The top entry reads combinationally from the storage array.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t.
  - PC control-select encoding constants: HOLD, RET, CALL, JUMP, BRANCH, INC.
- One sub-module: ret_addr_stack, parametrised by D and RAS_DEPTH.
  - Inputs: clk, reset, clear, push, pop, push_data.
  - Outputs: top, full, empty.

Test Plan:
- Handshake: reset, start_addr=10, pulse req, all enables 0 → prog_ctr 10,11,12…; running=1. Halt at PC 15 → done=1 next cycle, prog_ctr stays 15.
- End address with D=8, END_ADDR=128: start_addr=125 → PC 125,126,127,128, then done=1. Second req with start_addr=0 → done=0, PC=0.
- Branch and wrap:
  - D=8, PC=2, branch_en with target=8'hFC (-4) → PC=254.
  - Free-run from 254 with END_ADDR=200 → 255, then 0.
- Call/ret nesting with RAS_DEPTH=2:
  - Calls from PC 3 to 20, from 21 to 40, from 41 to 60: third push dropped, ras_ovf=1, PC=60.
  - Ret at 60 → 22; ret → 4; third ret → ras_unf=1, PC=5.
- Priority and stall:
  - halt+call+jump together → DONE with no push.
  - ret+call together → pop only.
  - stall held 3 cycles → PC frozen while cycle_cnt advances by 3.
- Reset mid-run at PC 50 with RAS occupancy 1 → next cycle IDLE, PC=0, RAS empty, cycle_cnt=0. Saturation check with CW=4: 20 RUN cycles → cycle_cnt=15.
